mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port round-robin arbiter sharing the single-port synchronous data memory of the matrix encoder. Requester 0 is the encoder controller's write/read path and requester 1 is the host readback/load path. It registers grants, holds a grant for a burst while the owner keeps requesting, and caps bursts so the other side cannot starve. It drives the memory port muxes and returns read-valid strobes to the owner of each read.

## Interface
- ADDR_W, 8, memory address width
- DATA_W, 8, memory data width
- MAX_BURST, 16, maximum consecutive accesses per grant (≥2)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req0 / req1  in  1  access request, held while accessing
- we0 / we1  in  1  1 = write, 0 = read, valid with req
- addr0 / addr1  in  ADDR_W  access address
- wdata0 / wdata1  in  DATA_W  write data
- gnt0 / gnt1  out  1  registered grant, one-hot or zero
- rvalid0 / rvalid1  out  1  read data valid for requester
- rdata  out  DATA_W  read data, shared, pass-through of mem_rdata
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, 1-cycle latency
- busy  out  1  high whenever gnt0 | gnt1

## Operation
- States: IDLE, OWN0, OWN1. gnt0 = (state==OWN0), gnt1 = (state==OWN1).
- Round-robin pointer `last` (1 bit) = last owner; reset to 1 so requester 0 wins first tie.
- IDLE: only reqN → OWNN. Both → owner = ~last. Neither → stay.
- OWNN, access cycle = reqN high; mem_en=1, mem_we=weN, mem_addr/mem_wdata from port N. Other port's signals ignored.
- Burst counter bcnt (width ceil(log2 MAX_BURST)) clears on entering OWNN, increments per access cycle.
- OWNN exit: reqN low → OWN(other) if other req high, else IDLE; no access that cycle. Access with bcnt==MAX_BURST-1 and other req high → OWN(other) (final access completes). Otherwise stay.
- Handover is direct OWN0↔OWN1, no idle bubble; `last` updates on every transition out of OWNN.
- Access with bcnt==MAX_BURST-1 and other req low: stay, bcnt wraps to 0.
- mem_en=0 outside access cycles; mem_addr/mem_wdata/mem_we = 0 when mem_en=0.
- Read access by N in cycle t → rvalidN=1 in cycle t+1, rdata = mem_rdata. Sets even if grant moved at t+1.
- Requester lowering reqN while not granted: no effect, no grant later.

## Timing
- Reset (async): state IDLE, last=1, bcnt=0; gnt0, gnt1, rvalid0, rvalid1, busy, mem_en, mem_we = 0; mem_addr, mem_wdata = 0; rdata follows mem_rdata.
- req in IDLE at edge k → gnt at k+1; first access in cycle after k+1 edge.
- Max wait for a requesting port under contention: MAX_BURST + 1 cycles.
- Reset mid-burst: grant and pending rvalid dropped immediately; in-flight read is lost.
- Outputs gnt*, rvalid*, busy are registered; mem_* are combinational from state and owner port inputs.

## Configuration
- ARB_BURST_LIMIT_EN defined: MAX_BURST cap enforced as above.
- Not defined: no bcnt, grant held while owner's req high regardless of the other port; MAX_BURST unused.

## Test plan
- Reset then req0=1 we0=1 addr0=0x05 wdata0=0xA3 → gnt0 next cycle, mem_en=1 mem_we=1 mem_addr=0x05 mem_wdata=0xA3 next.
- req0, req1 rise same cycle after reset → gnt0 first; req0 drops after 3 accesses → gnt1 the next cycle, no idle cycle.
- req0 held, req1 held, MAX_BURST=16 (limit enabled) → exactly 16 port-0 accesses then gnt1; 16 port-1 accesses then gnt0 again.
- Same with macro undefined → gnt0 held indefinitely until req0 drops; gnt1 then asserts next cycle.
- Port 1 reads addr 0x10 holding 0x5C → rvalid1=1 with rdata=0x5C one cycle after access; rvalid0 stays 0.
- rst asserted mid-burst of OWN1 → gnt1, busy, mem_en, rvalid1 go 0 asynchronously; after release with both req high, gnt0 first.

Source files
------------

// File: rtl/mem_arbiter.sv
// Round-robin arbiter: two requesters share one single-port synchronous memory.
// Latency: request seen in IDLE at edge k -> grant after edge k+1; read data valid one cycle after the access.
// Backpressure: a requester waits by holding req until granted; the burst cap (ARB_BURST_LIMIT_EN) bounds the wait to MAX_BURST+1 cycles.
//
// Build option: define ARB_BURST_LIMIT_EN to cap each grant at MAX_BURST consecutive
// accesses when the other side is waiting. Without it a grant is held while its owner
// keeps requesting, and MAX_BURST has no effect.

module mem_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] wdata0,

    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata1,

    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata,

    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    state_t state;
    state_t state_nxt;

    // Last owner; starts at 1 so requester 0 wins the first tie.
    logic last;
    logic last_nxt;

    // An access cycle is a cycle where the current owner still holds its request.
    logic acc;
    assign acc = ((state == OWN0) && req0) || ((state == OWN1) && req1);

    // Final access of a capped burst.
    logic burst_end;

`ifdef ARB_BURST_LIMIT_EN
    localparam int BW = $clog2(MAX_BURST);
    localparam logic [BW-1:0] BCNT_LAST = BW'(MAX_BURST - 1);

    logic [BW-1:0] bcnt;

    assign burst_end = acc && (bcnt == BCNT_LAST);

    // Burst counter: clear on any grant change, count access cycles, wrap at the cap
    // when the owner keeps the grant because nobody else is waiting.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcnt <= '0;
        end else if (state_nxt != state) begin
            bcnt <= '0;
        end else if (acc) begin
            bcnt <= burst_end ? '0 : bcnt + 1'b1;
        end
    end
`else
    // No cap in this build: MAX_BURST has no role.
    logic unused_max_burst;
    assign unused_max_burst = ^MAX_BURST;
    assign burst_end        = 1'b0;
`endif

    // State and round-robin pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b1;
        end else begin
            state <= state_nxt;
            last  <= last_nxt;
        end
    end

    // Next-state: grant from IDLE, release when the owner drops req, hand over on a capped burst.
    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        case (state)
            IDLE: begin
                if (req0 && req1) begin
                    state_nxt = last ? OWN0 : OWN1;
                end else if (req0) begin
                    state_nxt = OWN0;
                end else if (req1) begin
                    state_nxt = OWN1;
                end
            end
            OWN0: begin
                if (!req0) begin
                    state_nxt = req1 ? OWN1 : IDLE;
                    last_nxt  = 1'b0;
                end else if (burst_end && req1) begin
                    state_nxt = OWN1;
                    last_nxt  = 1'b0;
                end
            end
            OWN1: begin
                if (!req1) begin
                    state_nxt = req0 ? OWN0 : IDLE;
                    last_nxt  = 1'b1;
                end else if (burst_end && req0) begin
                    state_nxt = OWN0;
                    last_nxt  = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Memory port mux: the owner's signals during access cycles, all zero otherwise.
    always_comb begin
        mem_en    = acc;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (acc) begin
            if (state == OWN1) begin
                mem_we    = we1;
                mem_addr  = addr1;
                mem_wdata = wdata1;
            end else begin
                mem_we    = we0;
                mem_addr  = addr0;
                mem_wdata = wdata0;
            end
        end
    end

    // Read-valid strobes follow the read access by one cycle, tagged by who issued it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
        end else begin
            rvalid0 <= acc && (state == OWN0) && !we0;
            rvalid1 <= acc && (state == OWN1) && !we1;
        end
    end

    assign gnt0  = (state == OWN0);
    assign gnt1  = (state == OWN1);
    assign busy  = (state != IDLE);
    assign rdata = mem_rdata;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, burst/reset sequences, random traffic.
// Latency: checks every cycle at the falling edge against a behavioural model.
// Backpressure: requesters hold req until released by the stimulus; no stalls modelled.

module tb_mem_arbiter;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int MB = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req0 = 0, we0 = 0, req1 = 0, we1 = 0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, busy;
    logic [DW-1:0] rdata;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_BURST(MB)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata(rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .busy(busy)
    );

    // Single-port synchronous memory, 1-cycle read latency; reloaded while rst is high.
    logic [DW-1:0] tb_mem [256];
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 256; i++) tb_mem[i] <= 8'(i) ^ 8'h3C;
            tb_mem[16] <= 8'h5C;
        end else if (mem_en) begin
            if (mem_we) tb_mem[mem_addr] <= mem_wdata;
            else        mem_rdata <= tb_mem[mem_addr];
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Behavioural model: owner (-1 = nobody), last owner, accesses in the current grant,
    // pending read strobes and the data they must return.
    int            m_own;
    bit            m_last;
    int            m_cnt;
    bit            m_rv0, m_rv1;
    logic [DW-1:0] m_rd;

    // Snapshot of DUT outputs taken in the most recent step.
    logic          s_gnt0, s_gnt1, s_en, s_we, s_rv0, s_rv1;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wd, s_rdata;

    task automatic model_reset();
        m_own  = -1;
        m_last = 1'b1;
        m_cnt  = 0;
        m_rv0  = 1'b0;
        m_rv1  = 1'b0;
        m_rd   = '0;
    endtask

    // One clock: check outputs at the falling edge, then advance the model across the rising edge.
    task automatic step();
        bit            r [2];
        bit            w [2];
        logic [AW-1:0] a [2];
        logic [DW-1:0] d [2];
        bit            acc;
        int            o, nown, ncnt;
        bit            nlast, nrv0, nrv1;
        logic [DW-1:0] nrd;

        @(negedge clk);
        r[0] = req0; w[0] = we0; a[0] = addr0; d[0] = wdata0;
        r[1] = req1; w[1] = we1; a[1] = addr1; d[1] = wdata1;
        o   = (m_own < 0) ? 0 : m_own;
        acc = (m_own >= 0) && r[o];

        s_gnt0 = gnt0; s_gnt1 = gnt1; s_en = mem_en; s_we = mem_we;
        s_addr = mem_addr; s_wd = mem_wdata; s_rv0 = rvalid0; s_rv1 = rvalid1; s_rdata = rdata;

        chk("gnt0", gnt0, m_own == 0);
        chk("gnt1", gnt1, m_own == 1);
        chk("busy", busy, m_own >= 0);
        chk("rvalid0", rvalid0, m_rv0);
        chk("rvalid1", rvalid1, m_rv1);
        chk("mem_en", mem_en, acc);
        chk("mem_we", mem_we, acc ? w[o] : 1'b0);
        chk("mem_addr", mem_addr, acc ? a[o] : 8'h00);
        chk("mem_wdata", mem_wdata, acc ? d[o] : 8'h00);
        chk("rdata_pass", rdata, mem_rdata);
        if (m_rv0 || m_rv1) chk("rdata_value", rdata, m_rd);

        nrv0  = acc && (o == 0) && !w[0];
        nrv1  = acc && (o == 1) && !w[1];
        nrd   = tb_mem[a[o]];
        nown  = m_own;
        nlast = m_last;
        ncnt  = m_cnt;
        if (m_own < 0) begin
            if (r[0] && r[1]) nown = m_last ? 0 : 1;
            else if (r[0])    nown = 0;
            else if (r[1])    nown = 1;
            ncnt = 0;
        end else if (!r[o]) begin
            nown  = r[1-o] ? 1 - o : -1;
            nlast = (o == 1);
            ncnt  = 0;
        end else begin
`ifdef ARB_BURST_LIMIT_EN
            if ((m_cnt % MB) == MB - 1 && r[1-o]) begin
                nown  = 1 - o;
                nlast = (o == 1);
                ncnt  = 0;
            end else begin
                ncnt = m_cnt + 1;
            end
`else
            ncnt = m_cnt + 1;
`endif
        end

        @(posedge clk);
        m_own = nown; m_last = nlast; m_cnt = ncnt;
        m_rv0 = nrv0; m_rv1 = nrv1; m_rd = nrd;
        #1;
    endtask

    task automatic clear_inputs();
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        #2 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    typedef struct {
        logic          r0, w0;
        logic [AW-1:0] a0;
        logic [DW-1:0] d0;
        logic          r1, w1;
        logic [AW-1:0] a1;
        logic [DW-1:0] d1;
        logic          g0, g1, en, we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wd;
        logic          rv0, rv1;
        logic [DW-1:0] rd;
    } vec_t;

    vec_t tv [11];

    initial begin
        int n0, n1;
        bit saw;

        // {r0,w0,a0,d0, r1,w1,a1,d1 | gnt0,gnt1,en,we,addr,wdata, rv0,rv1,rdata}
        tv[0]  = '{1, 1, 8'h05, 8'hA3, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00};
        tv[1]  = '{1, 1, 8'h05, 8'hA3, 0, 0, 8'h00, 8'h00, 1, 0, 1, 1, 8'h05, 8'hA3, 0, 0, 8'h00};
        tv[2]  = '{1, 0, 8'h05, 8'h11, 1, 0, 8'h10, 8'h22, 1, 0, 1, 0, 8'h05, 8'h11, 0, 0, 8'h00};
        tv[3]  = '{0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h22, 1, 0, 0, 0, 8'h00, 8'h00, 1, 0, 8'hA3};
        tv[4]  = '{0, 0, 8'h00, 8'h00, 1, 0, 8'h10, 8'h22, 0, 1, 1, 0, 8'h10, 8'h22, 0, 0, 8'h00};
        tv[5]  = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 1, 0, 0, 8'h00, 8'h00, 0, 1, 8'h5C};
        tv[6]  = '{0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00};
        tv[7]  = '{1, 1, 8'h20, 8'h01, 1, 1, 8'h30, 8'h02, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00};
        tv[8]  = '{1, 1, 8'h20, 8'h01, 1, 1, 8'h30, 8'h02, 1, 0, 1, 1, 8'h20, 8'h01, 0, 0, 8'h00};
        tv[9]  = '{0, 0, 8'h00, 8'h00, 1, 1, 8'h30, 8'h02, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00};
        tv[10] = '{0, 0, 8'h00, 8'h00, 1, 1, 8'h30, 8'h02, 0, 1, 1, 1, 8'h30, 8'h02, 0, 0, 8'h00};

        // Reset state, observed before any clock edge.
        model_reset();
        #1 rst = 1'b1;
        #2;
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_rvalid1", rvalid1, 0);
        chk("rst_mem_en", mem_en, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed vector table.
        for (int i = 0; i < 11; i++) begin
            req0 = tv[i].r0; we0 = tv[i].w0; addr0 = tv[i].a0; wdata0 = tv[i].d0;
            req1 = tv[i].r1; we1 = tv[i].w1; addr1 = tv[i].a1; wdata1 = tv[i].d1;
            step();
            chk($sformatf("vec%0d_gnt0", i), s_gnt0, tv[i].g0);
            chk($sformatf("vec%0d_gnt1", i), s_gnt1, tv[i].g1);
            chk($sformatf("vec%0d_mem_en", i), s_en, tv[i].en);
            chk($sformatf("vec%0d_mem_we", i), s_we, tv[i].we);
            chk($sformatf("vec%0d_mem_addr", i), s_addr, tv[i].addr);
            chk($sformatf("vec%0d_mem_wdata", i), s_wd, tv[i].wd);
            chk($sformatf("vec%0d_rvalid0", i), s_rv0, tv[i].rv0);
            chk($sformatf("vec%0d_rvalid1", i), s_rv1, tv[i].rv1);
            if (tv[i].rv0 || tv[i].rv1) chk($sformatf("vec%0d_rdata", i), s_rdata, tv[i].rd);
        end

        // Both ports hold requests continuously.
        do_reset();
        req0 = 1; we0 = 0; addr0 = 8'h40;
        req1 = 1; we1 = 0; addr1 = 8'h50;
        step();
`ifdef ARB_BURST_LIMIT_EN
        n0 = 0; saw = 0;
        for (int i = 0; i < 60 && !saw; i++) begin
            step();
            if (s_gnt1) saw = 1;
            else if (s_gnt0 && s_en) n0++;
        end
        chk("burst0_handover_seen", saw, 1);
        chk("burst0_len", n0, MB);
        n1 = s_en ? 1 : 0;
        saw = 0;
        for (int i = 0; i < 60 && !saw; i++) begin
            step();
            if (s_gnt0) saw = 1;
            else if (s_gnt1 && s_en) n1++;
        end
        chk("burst1_handover_seen", saw, 1);
        chk("burst1_len", n1, MB);
`else
        n0 = 0; saw = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (s_gnt1) saw = 1;
            if (s_gnt0 && s_en) n0++;
        end
        chk("hold_no_gnt1", saw, 0);
        chk("hold_accesses", n0, 40);
        req0 = 0;
        step();
        chk("release_gnt0_still", s_gnt0, 1);
        chk("release_no_access", s_en, 0);
        step();
        chk("release_gnt1", s_gnt1, 1);
`endif

        // Reset in the middle of a port-1 read burst.
        do_reset();
        req1 = 1; we1 = 0; addr1 = 8'h10;
        step();
        step();
        step();
        chk("pre_rst_gnt1", s_gnt1, 1);
        chk("pre_rst_rvalid1", s_rv1, 1);
        #2 rst = 1'b1;
        #1;
        chk("midrst_gnt1", gnt1, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_mem_en", mem_en, 0);
        chk("midrst_rvalid1", rvalid1, 0);
        req0 = 1; we0 = 1; addr0 = 8'h60; wdata0 = 8'h77;
        @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        step();
        step();
        chk("post_rst_gnt0_first", s_gnt0, 1);

        // Random traffic against the model.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(3) == 0) req0 = ~req0;
            if ($urandom_range(3) == 0) req1 = ~req1;
            we0    = 1'($urandom_range(1));
            we1    = 1'($urandom_range(1));
            addr0  = 8'($urandom);
            addr1  = 8'($urandom);
            wdata0 = 8'($urandom);
            wdata1 = 8'($urandom);
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
